mem_responder: RTL and testbench

- Unified instruction/data memory that answers the multicycle controller's memory requests (memread, memwrite, with the address already muxed by IorD in the datapath).
- Adds a programmable wait-state counter and a mem_ready completion pulse, so the controller can be made latency-tolerant.
- Sits between the datapath address/write-data buses and the memory array. It is the responder end of the controller's memory interface.

---
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder with programmable wait states and a mem_ready pulse.
// Optional alignment checking (err port) is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        busy
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          op_write_q;
    logic          misalign_q;
    logic [31:0]   mem [WORDS];

    logic [AW-1:0] idx_in;
    logic          req;
    logic          misalign_in;

    assign idx_in = addr[AW+1:2];
    assign req    = memread | memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_in = (addr[1:0] != 2'b00);
    assign err         = (state == RESP) && misalign_q;
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];
`else
    assign misalign_in = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

    assign mem_ready = (state == RESP);
    assign busy      = (state != IDLE);

    // WAIT leaves on the cycle the counter steps from 1 to 0, so mem_ready
    // occupies the LATENCY-th cycle after acceptance for every LATENCY >= 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            misalign_q <= 1'b0;
            read_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q      <= idx_in;
                        wdata_q    <= write_data;
                        op_write_q <= memwrite;
                        misalign_q <= misalign_in;
                        cnt        <= CNT_LOAD;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                            if (!memwrite && !misalign_in)
                                read_data <= mem[idx_in];
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        if (!op_write_q && !misalign_q)
                            read_data <= mem[idx_q];
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commit happens only on the edge leaving RESP, so a reset anywhere earlier drops the write.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && op_write_q && !misalign_q)
            mem[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (LATENCY=2, WORDS=256); covers the
// alignment-check build when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_ready;
    logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        err;
`endif

    int nvec  = 0;
    int nfail = 0;

    mem_responder #(.WORDS(256), .LATENCY(2), .AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .busy       (busy)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until mem_ready, drop it, then step back to IDLE.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rdat, output logic err_seen);
        memread    = rd;
        memwrite   = wr;
        addr       = a;
        write_data = d;
        lat        = 0;
        rdat       = '0;
        err_seen   = 1'b0;
        do begin
            tick;
            lat++;
        end while (!mem_ready && lat < 20);
        rdat = read_data;
`ifdef MEM_ALIGN_CHECK_EN
        err_seen = err;
`endif
        memread  = 1'b0;
        memwrite = 1'b0;
        tick;
    endtask

    int          lat;
    logic [31:0] rdat;
    logic        e;
    logic [4:0]  mr_hist;

    initial begin
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; write_data = '0;
        tick; tick;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        tick;

        // First write, stepped by hand to watch busy and mem_ready timing
        memwrite = 1'b1; addr = 32'h10; write_data = 32'hDEADBEEF;
        tick;
        chk("w1_c1_busy", {31'b0, busy}, 32'h1);
        chk("w1_c1_ready", {31'b0, mem_ready}, 32'h0);
        tick;
        chk("w1_c2_busy", {31'b0, busy}, 32'h1);
        chk("w1_c2_ready", {31'b0, mem_ready}, 32'h1);
        memwrite = 1'b0;
        tick;
        chk("w1_c3_busy", {31'b0, busy}, 32'h0);
        chk("w1_c3_ready", {31'b0, mem_ready}, 32'h0);

        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, e);
        chk("r10_latency", lat, 32'd2);
        chk("r10_data", rdat, 32'hDEADBEEF);

        // Read+write together: write wins, read_data untouched in its RESP
        xact(1'b1, 1'b1, 32'h20, 32'h12345678, lat, rdat, e);
        chk("rw20_latency", lat, 32'd2);
        chk("rw20_read_data_held", rdat, 32'hDEADBEEF);
        xact(1'b1, 1'b0, 32'h20, 32'h0, lat, rdat, e);
        chk("r20_data", rdat, 32'h12345678);

        // Alias: 0x400 maps onto word 0
        xact(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, lat, rdat, e);
        xact(1'b1, 1'b0, 32'h000, 32'h0, lat, rdat, e);
        chk("alias_r0_data", rdat, 32'hA5A5A5A5);
        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, e);
        chk("alias_r10_intact", rdat, 32'hDEADBEEF);

        // Reset during WAIT of a write
        xact(1'b0, 1'b1, 32'h30, 32'h0, lat, rdat, e);
        memwrite = 1'b1; addr = 32'h30; write_data = 32'hCAFEF00D;
        tick;
        chk("rstw_busy_wait", {31'b0, busy}, 32'h1);
        reset = 1'b1; memwrite = 1'b0;
        tick;
        chk("rstw_busy", {31'b0, busy}, 32'h0);
        chk("rstw_ready", {31'b0, mem_ready}, 32'h0);
        reset = 1'b0;
        tick;
        chk("rstw_ready_after", {31'b0, mem_ready}, 32'h0);
        xact(1'b1, 1'b0, 32'h30, 32'h0, lat, rdat, e);
        chk("rstw_r30_data", rdat, 32'h0);

        // Request held through RESP: pulses in cycles 2 and 5 after the first accept
        memread = 1'b1; addr = 32'h10;
        mr_hist = '0;
        for (int i = 0; i < 5; i++) begin
            tick;
            mr_hist[i] = mem_ready;
        end
        memread = 1'b0;
        chk("held_ready_pattern", {27'b0, mr_hist}, 32'h12);
        chk("held_read_data", read_data, 32'hDEADBEEF);
        tick; tick;
        chk("held_idle_busy", {31'b0, busy}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        xact(1'b0, 1'b1, 32'h40, 32'h55AA55AA, lat, rdat, e);
        chk("al_w40_err", {31'b0, e}, 32'h0);
        xact(1'b0, 1'b1, 32'h42, 32'h11111111, lat, rdat, e);
        chk("al_w42_latency", lat, 32'd2);
        chk("al_w42_err", {31'b0, e}, 32'h1);
        xact(1'b1, 1'b0, 32'h40, 32'h0, lat, rdat, e);
        chk("al_r40_data", rdat, 32'h55AA55AA);
        chk("al_r40_err", {31'b0, e}, 32'h0);
        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, e);
        xact(1'b1, 1'b0, 32'h43, 32'h0, lat, rdat, e);
        chk("al_r43_err", {31'b0, e}, 32'h1);
        chk("al_r43_data_held", rdat, 32'hDEADBEEF);
`else
        xact(1'b0, 1'b1, 32'h42, 32'h11111111, lat, rdat, e);
        chk("na_w42_latency", lat, 32'd2);
        xact(1'b1, 1'b0, 32'h40, 32'h0, lat, rdat, e);
        chk("na_r40_data", rdat, 32'h11111111);
        xact(1'b1, 1'b0, 32'h43, 32'h0, lat, rdat, e);
        chk("na_r43_data", rdat, 32'h11111111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
